// File: rtl/mic_fifo_pkg.sv
// Shared definitions for the microphone record/playback controller and its FIFO.
package mic_fifo_pkg;

    // Sequencer states; the numeric values are exported on the State port.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_CLEAR  = 2'd1,
        ST_RECORD = 2'd2,
        ST_PLAY   = 2'd3
    } state_e;

    // FIFO geometry, shared with the fifo instance.
    localparam int FDEPTH  = 200000;
    localparam int FCWIDTH = 20;

    // 50 MHz system clock / 50 = 1 MHz microphone sample rate.
    localparam int DIV_DEFAULT = 50;

endpackage

// File: rtl/sample_tick_gen.sv
// Free-running sample divider: one-cycle tick at the end of each period and
// the microphone clock, high for the first half of the period.
module sample_tick_gen #(
    parameter int DIV = mic_fifo_pkg::DIV_DEFAULT
) (
    input  logic clk,
    input  logic srst,
    output logic tick,
    output logic mic_clk
);

    localparam int CNTW = $clog2(DIV);

    logic [CNTW-1:0] cnt_q, cnt_d;
    logic            tick_q, tick_d;
    logic            mic_clk_q, mic_clk_d;

    // Next count and outputs decoded from it, so the registered outputs
    // always correspond to the current count without combinational glitches.
    always_comb begin
        cnt_d     = (cnt_q == CNTW'(DIV - 1)) ? '0 : cnt_q + CNTW'(1);
        tick_d    = (cnt_d == CNTW'(DIV - 1));
        mic_clk_d = (cnt_d < CNTW'(DIV / 2));
    end

    // Divider registers; reset puts the count at 0 with the mic clock high.
    always_ff @(posedge clk) begin
        if (srst) begin
            cnt_q     <= '0;
            tick_q    <= 1'b0;
            mic_clk_q <= 1'b1;
        end else begin
            cnt_q     <= cnt_d;
            tick_q    <= tick_d;
            mic_clk_q <= mic_clk_d;
        end
    end

    assign tick    = tick_q;
    assign mic_clk = mic_clk_q;

endmodule

// File: rtl/mic_fifo_ctrl.sv
// Record/playback sequencer for the 1-bit microphone FIFO. Owns all FIFO
// strobes; every output is registered.
module mic_fifo_ctrl #(
    parameter int DIV    = mic_fifo_pkg::DIV_DEFAULT,
    parameter int FDEPTH = mic_fifo_pkg::FDEPTH,
    parameter int CW     = mic_fifo_pkg::FCWIDTH
) (
    input  logic          Clk,
    input  logic          Rst,
    input  logic          RecBtn,
    input  logic          PlayBtn,
    input  logic          Mic_Data,
    output logic          MicClk,
    output logic          Data_In,
    output logic          FClrN,
    output logic          FInN,
    output logic          FOutN,
    input  logic          F_Data,
    input  logic          F_FullN,
    input  logic          F_EmptyN,
    output logic          AudioOut,
    output logic          Busy,
    output logic [1:0]    State,
    output logic [CW-1:0] SampleCount
);

    import mic_fifo_pkg::*;

    localparam logic [CW-1:0] CNT_MAX = CW'(FDEPTH);

    logic tick;
    logic mic_clk;

    sample_tick_gen #(.DIV(DIV)) u_tick (
        .clk     (Clk),
        .srst    (Rst),
        .tick    (tick),
        .mic_clk (mic_clk)
    );

    logic          rec_prev_q, play_prev_q;
    logic          rec_edge, play_edge, any_edge;
    state_e        state_q, state_d;
    logic          fclrn_q, fclrn_d;
    logic          finn_q, finn_d;
    logic          foutn_q, foutn_d;
    logic          data_in_q, data_in_d;
    logic          audio_q, audio_d;
    logic          busy_q, busy_d;
    logic [CW-1:0] count_q, count_d;

    assign rec_edge  = RecBtn & ~rec_prev_q;
    assign play_edge = PlayBtn & ~play_prev_q;
    assign any_edge  = rec_edge | play_edge;

    // Sequencer next-state and strobe decode; strobes default inactive so
    // each one is a single-cycle pulse.
    always_comb begin
        state_d   = state_q;
        fclrn_d   = 1'b1;
        finn_d    = 1'b1;
        foutn_d   = 1'b1;
        data_in_d = data_in_q;
        audio_d   = audio_q;
        count_d   = count_q;

        // The head bit is captured on the edge that completes the read,
        // even if a button edge has just sent us back to IDLE.
        if (!foutn_q) begin
            audio_d = F_Data;
        end

        case (state_q)
            ST_IDLE: begin
                if (rec_edge) begin
                    state_d = ST_CLEAR;
                    fclrn_d = 1'b0;
                    count_d = '0;
                end else if (play_edge && F_EmptyN) begin
                    state_d = ST_PLAY;
                end
            end
            ST_CLEAR: begin
                state_d = ST_RECORD;
            end
            ST_RECORD: begin
                if (tick) begin
                    if (F_FullN) begin
                        data_in_d = Mic_Data;
                        finn_d    = 1'b0;
                        if (count_q < CNT_MAX) begin
                            count_d = count_q + CW'(1);
                        end
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                // A write decoded in this same cycle is still issued.
                if (any_edge) begin
                    state_d = ST_IDLE;
                end
            end
            ST_PLAY: begin
                if (tick) begin
                    if (F_EmptyN) begin
                        foutn_d = 1'b0;
                        if (count_q != '0) begin
                            count_d = count_q - CW'(1);
                        end
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                if (any_edge) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    // State, strobe, data and counter registers with synchronous reset.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            rec_prev_q  <= 1'b0;
            play_prev_q <= 1'b0;
            state_q     <= ST_IDLE;
            fclrn_q     <= 1'b1;
            finn_q      <= 1'b1;
            foutn_q     <= 1'b1;
            data_in_q   <= 1'b0;
            audio_q     <= 1'b0;
            busy_q      <= 1'b0;
            count_q     <= '0;
        end else begin
            rec_prev_q  <= RecBtn;
            play_prev_q <= PlayBtn;
            state_q     <= state_d;
            fclrn_q     <= fclrn_d;
            finn_q      <= finn_d;
            foutn_q     <= foutn_d;
            data_in_q   <= data_in_d;
            audio_q     <= audio_d;
            busy_q      <= busy_d;
            count_q     <= count_d;
        end
    end

    assign MicClk      = mic_clk;
    assign Data_In     = data_in_q;
    assign FClrN       = fclrn_q;
    assign FInN        = finn_q;
    assign FOutN       = foutn_q;
    assign AudioOut    = audio_q;
    assign Busy        = busy_q;
    assign State       = state_q;
    assign SampleCount = count_q;

endmodule
